// File: rtl/mux_2x1_8bits_interleave.sv
// Two-lane to one-lane byte interleaver: each lane is buffered in a small
// FIFO and the output strictly alternates lane 0, lane 1, lane 0, ...

// Per-lane FIFO. Pops are only requested by the arbiter when count_o != 0.
module mux_2x1_lane_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          wr_ok;

    // A full lane drops the byte even if it is popped at the same edge.
    assign full_o  = (count_q == FULL_CNT);
    assign wr_ok   = push_i && !full_o;
    assign drop_o  = push_i && full_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointer and count values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (reset_L && wr_ok) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module mux_2x1_8bits_interleave #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic                  validIn0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic                  validIn1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  validOut,
    output logic                  full0,
    output logic                  full1,
    output logic                  overflow
);
    localparam int NUM_LANES = 2;
    localparam int AW        = $clog2(FIFO_DEPTH);

    logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_din, lane_head;
    logic [NUM_LANES-1:0][AW:0]           lane_cnt;
    logic [NUM_LANES-1:0]                 lane_vld, lane_pop, lane_full, lane_drop;

    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  validOut_q, validOut_d;
    logic                  overflow_q, overflow_d;
    logic                  take;

    assign lane_din = {data_in1, data_in0};
    assign lane_vld = {validIn1, validIn0};

    // Arbiter decision uses only registered counts, so no input reaches it.
    assign take = (lane_cnt[sel_q] != '0);

    genvar l;
    generate
        for (l = 0; l < NUM_LANES; l++) begin : g_lane
            assign lane_pop[l] = take && (sel_q == 1'(l));
            mux_2x1_lane_fifo #(
                .W     (DATA_WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .reset_L (reset_L),
                .push_i  (lane_vld[l]),
                .data_i  (lane_din[l]),
                .pop_i   (lane_pop[l]),
                .head_o  (lane_head[l]),
                .count_o (lane_cnt[l]),
                .full_o  (lane_full[l]),
                .drop_o  (lane_drop[l])
            );
        end
    endgenerate

    // Wait on the expected lane; never skip to the other one.
    always_comb begin
        sel_d      = sel_q;
        data_out_d = data_out_q;
        validOut_d = 1'b0;
        overflow_d = overflow_q | (|lane_drop);
        if (take) begin
            data_out_d = lane_head[sel_q];
            validOut_d = 1'b1;
            sel_d      = ~sel_q;
        end
    end

    // Output, lane select and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            sel_q      <= 1'b0;
            data_out_q <= '0;
            validOut_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            data_out_q <= data_out_d;
            validOut_q <= validOut_d;
            overflow_q <= overflow_d;
        end
    end

    assign data_out = data_out_q;
    assign validOut = validOut_q;
    assign overflow = overflow_q;
    assign full0    = lane_full[0];
    assign full1    = lane_full[1];
endmodule

// File: tb/tb_mux_2x1_8bits_interleave.sv
// Directed bench for the two-lane byte interleaver. Cycle c of a test is the
// period after the c-th edge following reset release; inputs are driven and
// outputs sampled 1ns after the edge that starts the cycle.
module tb_mux_2x1_8bits_interleave;
    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] data_in0, data_in1, data_out;
    logic       validIn0, validIn1, validOut, full0, full1, overflow;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] exp_ov [8] = '{8'h81, 8'h02, 8'h82, 8'h03, 8'h83, 8'h04, 8'h84, 8'h05};
    logic [7:0] exp_fp [7] = '{8'hF1, 8'hE2, 8'hF2, 8'hE3, 8'hF3, 8'hE4, 8'hF4};

    mux_2x1_8bits_interleave #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset_L  (reset_L),
        .data_in0 (data_in0),
        .validIn0 (validIn0),
        .data_in1 (data_in1),
        .validIn1 (validIn1),
        .data_out (data_out),
        .validOut (validOut),
        .full0    (full0),
        .full1    (full1),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d);
        chk({tag, ".valid"}, 32'(validOut), 32'(v));
        chk({tag, ".data"},  32'(data_out), 32'(d));
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        validIn0 = v0; data_in0 = d0;
        validIn1 = v1; data_in1 = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        tick();
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L = 1'b0;
        drive(1'b1, 8'hFF, 1'b1, 8'hFF);
        #2;

        // Reset with inputs active
        tick(); tick();
        chk("rst.data", 32'(data_out), 32'h00);
        chk("rst.valid", 32'(validOut), 32'h0);
        chk("rst.full", 32'({full0, full1}), 32'h0);
        chk("rst.ovf", 32'(overflow), 32'h0);
        reset_L = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            chk("rst.idle_valid", 32'(validOut), 32'h0);
            tick();
        end

        // Paired stream
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            if (c < 3) drive(1'b1, 8'(8'h10 + 2*c), 1'b1, 8'(8'h11 + 2*c));
            else       drive(1'b0, 8'h00, 1'b0, 8'h00);
            if (c >= 2 && c <= 7) chk_out("pair", 1'b1, 8'(8'h10 + c - 2));
            if (c == 8) begin
                chk("pair.end_valid", 32'(validOut), 32'h0);
                chk("pair.ovf", 32'(overflow), 32'h0);
            end
            tick();
        end

        // Starved lane: output waits on lane 1, data_out holds
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            drive(c == 0 || c == 1, (c == 0) ? 8'hA0 : 8'hA2, c == 5, 8'hA1);
            if (c == 2) chk_out("starve.a0", 1'b1, 8'hA0);
            if (c >= 3 && c <= 6) chk_out("starve.hold", 1'b0, 8'hA0);
            if (c == 7) chk_out("starve.a1", 1'b1, 8'hA1);
            if (c == 8) chk_out("starve.a2", 1'b1, 8'hA2);
            tick();
        end

        // Overflow on lane 0, then drain against lane 1
        do_reset();
        for (int c = 0; c <= 18; c++) begin
            drive(c <= 5, 8'(c + 1), c >= 8 && c <= 11, 8'(8'h81 + c - 8));
            if (c == 2) chk_out("ovf.first", 1'b1, 8'h01);
            if (c == 4) chk("ovf.full0_pre", 32'(full0), 32'h0);
            if (c == 5) begin
                chk("ovf.full0", 32'(full0), 32'h1);
                chk("ovf.flag_pre", 32'(overflow), 32'h0);
            end
            if (c == 6) chk("ovf.flag", 32'(overflow), 32'h1);
            if (c >= 10 && c <= 17) chk_out("ovf.drain", 1'b1, exp_ov[c-10]);
            if (c == 18) begin
                chk("ovf.end_valid", 32'(validOut), 32'h0);
                chk("ovf.sticky", 32'(overflow), 32'h1);
            end
            tick();
        end

        // Reset mid-operation discards buffered bytes
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            reset_L = (c != 5);
            if (c <= 4)      drive(c == 3 || c == 4, (c == 3) ? 8'hC0 : 8'hC2, 1'b1, 8'(8'hB1 + c));
            else if (c == 6) drive(1'b1, 8'h55, 1'b1, 8'h66);
            else             drive(1'b0, 8'h00, 1'b0, 8'h00);
            if (c == 4) chk("mid.full1", 32'(full1), 32'h1);
            if (c == 5) begin
                chk_out("mid.pre", 1'b1, 8'hC0);
                chk("mid.ovf_pre", 32'(overflow), 32'h1);
            end
            if (c == 6) begin
                chk_out("mid.post", 1'b0, 8'h00);
                chk("mid.ovf_clr", 32'(overflow), 32'h0);
                chk("mid.full1_clr", 32'(full1), 32'h0);
            end
            if (c == 8)  chk_out("mid.55", 1'b1, 8'h55);
            if (c == 9)  chk_out("mid.66", 1'b1, 8'h66);
            if (c == 10) chk("mid.no_stale", 32'(validOut), 32'h0);
            tick();
        end
        reset_L = 1'b1;

        // Full lane 0 popped while a write arrives: write is dropped
        do_reset();
        for (int c = 0; c <= 17; c++) begin
            drive(c <= 4 || c == 7, 8'(8'hE0 + c),
                  c == 5 || (c >= 8 && c <= 10) || c == 14,
                  (c == 5) ? 8'hF0 : (c == 14) ? 8'hF4 : 8'(8'hF0 + c - 7));
            if (c == 2) chk_out("fp.e0", 1'b1, 8'hE0);
            if (c == 7) begin
                chk_out("fp.f0", 1'b1, 8'hF0);
                chk("fp.full0", 32'(full0), 32'h1);
                chk("fp.ovf_pre", 32'(overflow), 32'h0);
            end
            if (c == 8) begin
                chk_out("fp.e1", 1'b1, 8'hE1);
                chk("fp.ovf", 32'(overflow), 32'h1);
                chk("fp.full0_clr", 32'(full0), 32'h0);
            end
            if (c >= 10 && c <= 16) chk_out("fp.drain", 1'b1, exp_fp[c-10]);
            if (c == 17) chk("fp.no_e5", 32'(validOut), 32'h0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
